// File: rtl/flag_pkg.sv
// ============================================================================
// flag_pkg: shared types for the flag/branch unit (cc codes, flag classes,
// FSM states, opcode classing). Revision: 1.0
// ============================================================================
`default_nettype none

package flag_pkg;

  localparam logic [2:0] CC_NEQ  = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_UNC  = 3'b111;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_Z    = 2'd1,
    FC_ALL  = 2'd2
  } flag_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  typedef struct packed {
    logic ov;
    logic zr;
    logic neg;
  } flags_t;

  function automatic flag_class_e op_class(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010:                   return FC_ALL;
      4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111:                   return FC_Z;
      default:                            return FC_NONE;
    endcase
  endfunction

  // Overlay the ALU's flags onto the current set according to the op's class.
  function automatic flags_t apply_flags(input flags_t cur, input flag_class_e cls,
                                         input flags_t alu);
    flags_t res;
    res = cur;
    case (cls)
      FC_ALL:  res = alu;
      FC_Z:    res.zr = alu.zr;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flag_branch_unit_cond_eval.sv
// ============================================================================
// cond_eval: combinational branch condition evaluation (cc + flags -> taken).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] cc,
  input  flags_t     flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_NEQ:  taken = ~flags.zr;
      CC_EQ:   taken = flags.zr;
      CC_GT:   taken = ~flags.zr & ~flags.neg;
      CC_LT:   taken = flags.neg;
      CC_GTE:  taken = flags.zr | ~flags.neg;
      CC_LTE:  taken = flags.neg | flags.zr;
      CC_OVFL: taken = flags.ov;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flag_branch_unit.sv
// ============================================================================
// flag_branch_unit: architectural ov/zr/neg register, outstanding flag-writer
// tracking and branch resolution. Optional macro FLAG_FWD_EN adds a WAIT-state
// bypass resolving against the retiring writer's flags. Revision: 1.0
// ============================================================================
`default_nettype none

module flag_branch_unit
  import flag_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alu_op,
  input  logic       alu_ov,
  input  logic       alu_zr,
  input  logic       alu_neg,
  input  logic       flag_wr,
  input  logic       flag_iss,
  input  logic       br_req,
  input  logic [2:0] br_cc,
  output logic       br_rdy,
  output logic       br_done,
  output logic       br_taken,
  output logic       stall,
  output logic       ov,
  output logic       zr,
  output logic       neg,
  output logic       err
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_e             state_q, state_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               err_q, err_d;
  flags_t             flags_q, flags_d;
  logic [2:0]         cc_q, cc_d;

  logic               iss_only;
  logic               wr_only;
  logic               taken_reg;
  flags_t             alu_flags;

  assign iss_only  = flag_iss & ~flag_wr;
  assign wr_only   = flag_wr & ~flag_iss;
  assign alu_flags = '{ov: alu_ov, zr: alu_zr, neg: alu_neg};

  // Saturating in-flight counter; an overflow or underflow attempt only sets err.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (iss_only) begin
      if (pend_q == PEND_MAX) err_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end else if (wr_only) begin
      if (pend_q == '0) err_d = 1'b1;
      else              pend_d = pend_q - PEND_ONE;
    end
  end

  assign flags_d = flag_wr ? apply_flags(flags_q, op_class(alu_op), alu_flags) : flags_q;

  cond_eval u_eval_reg (
    .cc    (cc_q),
    .flags (flags_q),
    .taken (taken_reg)
  );

`ifdef FLAG_FWD_EN
  logic taken_fwd;
  logic fwd_hit;

  // flags_d already holds the retiring writer's flags merged over the register.
  cond_eval u_eval_fwd (
    .cc    (cc_q),
    .flags (flags_d),
    .taken (taken_fwd)
  );

  assign fwd_hit = (state_q == ST_WAIT) && (pend_q == PEND_ONE) && wr_only;
`endif

  always_comb begin
    state_d  = state_q;
    cc_d     = cc_q;
    br_rdy   = 1'b0;
    br_done  = 1'b0;
    br_taken = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        br_rdy = 1'b1;
        if (br_req) begin
          cc_d    = br_cc;
          state_d = (pend_d == '0) ? ST_RESOLVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
`ifdef FLAG_FWD_EN
        if (fwd_hit) begin
          br_done  = 1'b1;
          br_taken = taken_fwd;
          state_d  = ST_IDLE;
        end else
`endif
        if (pend_d == '0) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        br_done  = 1'b1;
        br_taken = taken_reg;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      err_q   <= 1'b0;
      flags_q <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      flags_q <= flags_d;
      cc_q    <= cc_d;
    end
  end

  assign ov  = flags_q.ov;
  assign zr  = flags_q.zr;
  assign neg = flags_q.neg;
  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// ============================================================================
// tb_flag_branch_unit: directed + randomized bench against a behavioural
// model of the flag/branch unit (honours FLAG_FWD_EN). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_flag_branch_unit;

  localparam int PEND_MAX = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_op = '0;
  logic       alu_ov = 1'b0, alu_zr = 1'b0, alu_neg = 1'b0;
  logic       flag_wr = 1'b0, flag_iss = 1'b0, br_req = 1'b0;
  logic [2:0] br_cc = '0;
  logic       br_rdy, br_done, br_taken, stall, ov, zr, neg, err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending count, flags, and the life of one branch.
  int     m_pend;
  bit     m_err, m_ov, m_zr, m_neg;
  bit     m_br_waiting;   // accepted, earlier writers still outstanding
  bit     m_br_due;       // result is presented this cycle
  bit [2:0] m_cc;

  flag_branch_unit #(.PEND_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .alu_ov(alu_ov), .alu_zr(alu_zr),
    .alu_neg(alu_neg), .flag_wr(flag_wr), .flag_iss(flag_iss), .br_req(br_req),
    .br_cc(br_cc), .br_rdy(br_rdy), .br_done(br_done), .br_taken(br_taken),
    .stall(stall), .ov(ov), .zr(zr), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond(input bit [2:0] cc, input bit f_ov, input bit f_zr, input bit f_neg);
    case (cc)
      0: return !f_zr;
      1: return f_zr;
      2: return !f_zr && !f_neg;
      3: return f_neg;
      4: return f_zr || !f_neg;
      5: return f_neg || f_zr;
      6: return f_ov;
      default: return 1'b1;
    endcase
  endfunction

  // 2 = loads all flags, 1 = loads zr only, 0 = no change
  function automatic int op_kind(input bit [3:0] op);
    if (op == 0 || op == 2) return 2;
    if (op >= 3 && op <= 7) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    m_pend = 0; m_err = 0; m_ov = 0; m_zr = 0; m_neg = 0;
    m_br_waiting = 0; m_br_due = 0; m_cc = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    flag_iss = 0; flag_wr = 0; br_req = 0; alu_op = 0;
    rst_n = 0;
    #1;
    model_clear();
    chk({tag, "_rdy"}, br_rdy, 1);
    chk({tag, "_done"}, br_done, 0);
    chk({tag, "_taken"}, br_taken, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_flags"}, {ov, zr, neg}, 0);
    chk({tag, "_err"}, err, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock cycle: drive, check against model, advance model at the edge.
  task automatic step(input bit iss, input bit wr, input bit [3:0] op, input bit a_ov,
                      input bit a_zr, input bit a_neg, input bit req, input bit [2:0] cc,
                      output bit accepted);
    bit e_done, e_taken, e_rdy, fwd;
    bit n_ov, n_zr, n_neg;
    int k;
    @(negedge clk);
    flag_iss = iss; flag_wr = wr; alu_op = op; alu_ov = a_ov; alu_zr = a_zr;
    alu_neg = a_neg; br_req = req; br_cc = cc;
    #1;
    n_ov = m_ov; n_zr = m_zr; n_neg = m_neg;
    k = op_kind(op);
    if (wr && k == 2) begin n_ov = a_ov; n_zr = a_zr; n_neg = a_neg; end
    if (wr && k == 1) n_zr = a_zr;
    e_done  = m_br_due;
    e_taken = m_br_due ? cond(m_cc, m_ov, m_zr, m_neg) : 1'b0;
    e_rdy   = !m_br_waiting && !m_br_due;
    fwd     = 0;
`ifdef FLAG_FWD_EN
    if (m_br_waiting && m_pend == 1 && wr && !iss) begin
      fwd = 1; e_done = 1; e_taken = cond(m_cc, n_ov, n_zr, n_neg);
    end
`endif
    chk("rdy", br_rdy, e_rdy);
    chk("done", br_done, e_done);
    chk("taken", br_taken, e_taken);
    chk("stall", stall, m_br_waiting);
    chk("flags", {ov, zr, neg}, {m_ov, m_zr, m_neg});
    chk("err", err, m_err);
    accepted = req && e_rdy;
    @(posedge clk);
    if (iss && !wr) begin
      if (m_pend == PEND_MAX) m_err = 1; else m_pend++;
    end else if (wr && !iss) begin
      if (m_pend == 0) m_err = 1; else m_pend--;
    end
    m_ov = n_ov; m_zr = n_zr; m_neg = n_neg;
    if (m_br_due) m_br_due = 0;
    else if (m_br_waiting) begin
      if (fwd) m_br_waiting = 0;
      else if (m_pend == 0) begin m_br_waiting = 0; m_br_due = 1; end
    end else if (req) begin
      m_cc = cc;
      if (m_pend == 0) m_br_due = 1; else m_br_waiting = 1;
    end
  endtask

  bit acc;
  bit hold;
  bit [2:0] hcc;
  bit r_iss, r_wr, r_req;
  bit [2:0] r_cc;

  initial begin
    model_clear();
    do_reset("rst0");

    // Underflow sets sticky err until reset
    step(0, 1, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    chk("err_sticky", err, 1);
    do_reset("rst1");

    // ADD sets all flags, then OVFL and GT branches
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 4'h0, 1, 0, 1, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b110, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b010, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    chk("add_flags", {ov, zr, neg}, 3'b101);

    // Logic op loads zr only
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 4'h3, 0, 1, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b001, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    chk("zop_flags", {ov, zr, neg}, 3'b111);

    // Branch stalls behind two writers
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b111, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 4'h2, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 4'h0, 0, 1, 0, 0, 0, acc);
    repeat (3) step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);

    // NONE-class op, then simultaneous iss/wr at pend=3
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 4'h8, 1, 1, 1, 0, 0, acc);
    repeat (3) step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(1, 1, 4'h0, 1, 1, 1, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b000, acc);
    repeat (2) step(0, 1, 4'h9, 0, 0, 0, 0, 0, acc);
    step(1, 1, 4'h2, 0, 0, 1, 0, 0, acc);
    step(0, 1, 4'h5, 0, 0, 0, 0, 0, acc);
    repeat (2) step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);

    // Reset while waiting drops the branch
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 4'h0, 0, 0, 0, 1, 3'b111, acc);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);
    do_reset("rst_wait");
    repeat (3) step(0, 0, 4'h0, 0, 0, 0, 0, 0, acc);

    // Randomized traffic
    hold = 0; hcc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (($urandom % 700) == 0) begin
        do_reset("rst_rand");
        hold = 0;
      end
      r_iss = (($urandom % 3) == 0) && (m_pend < PEND_MAX || ($urandom % 16) == 0);
      r_wr  = (($urandom % 3) == 0) && (m_pend > 0 || ($urandom % 32) == 0);
      if (hold) begin
        r_req = 1; r_cc = hcc;
      end else begin
        r_req = ($urandom % 5) == 0;
        r_cc  = 3'($urandom);
      end
      step(r_iss, r_wr, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           r_req, r_cc, acc);
      hold = r_req && !acc;
      hcc  = r_cc;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
